// File: rtl/booth_mul_block_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
package booth_mul_block_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Booth pair is {Q[0], Q_1}; 2'b11 behaves like BOOTH_NOP
  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  function automatic int unsigned count_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/booth_mul_block_sum_block.sv
// Ripple-carry adder used for both A+M and A-M (inverted b, carry_in=1).
module sum_block #(
  parameter int unsigned W = 65
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         carry_in_i,
  output logic [W-1:0] out_o
);

  logic carry;

  always_comb begin
    out_o = '0;
    carry = carry_in_i;
    for (int i = 0; i < int'(W); i++) begin
      out_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
  end

endmodule

// File: rtl/booth_mul_block.sv
// Sequential signed radix-2 Booth multiplier, one add/sub/nop plus shift per clock.
// Define BOOTH_OPCOUNT_EN to add the op_count port (number of add/sub iterations).
module booth_mul_block
  import booth_mul_block_pkg::*;
#(
  parameter int unsigned w = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [w-1:0]     in_a,
  input  logic [w-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*w-1:0]   out_p
`ifdef BOOTH_OPCOUNT_EN
  ,
  output logic [count_width(w)-1:0] op_count
`endif
);

  localparam int unsigned AW = w + 1;
  localparam int unsigned CW = count_width(w);
  localparam int unsigned PW = 2 * w;

  state_e         state_q;
  logic [AW-1:0]  m_q;
  logic [AW-1:0]  a_q;
  logic [w-1:0]   q_q;
  logic           q1_q;
  logic [CW-1:0]  cnt_q;
  logic [PW-1:0]  p_q;

  logic [1:0]     pair_c;
  logic           op_c;
  logic           sub_c;
  logic [AW-1:0]  add_b_c;
  logic [AW-1:0]  sum_c;
  logic [AW-1:0]  a_new_c;
  logic [AW-1:0]  a_d;
  logic [w-1:0]   q_d;
  logic           q1_d;

  // Adder is driven every cycle; its result is only used on add/sub pairs
  always_comb begin
    pair_c  = {q_q[0], q1_q};
    sub_c   = (pair_c == BOOTH_SUB);
    op_c    = (pair_c == BOOTH_ADD) || sub_c;
    add_b_c = sub_c ? ~m_q : m_q;
    a_new_c = op_c ? sum_c : a_q;
    a_d     = {a_new_c[AW-1], a_new_c[AW-1:1]};
    q_d     = {a_new_c[0], q_q[w-1:1]};
    q1_d    = q_q[0];
  end

  sum_block #(.W(AW)) u_sum (
    .a_i        (a_q),
    .b_i        (add_b_c),
    .carry_in_i (sub_c),
    .out_o      (sum_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            m_q     <= {in_a[w-1], in_a};
            q_q     <= in_b;
            a_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          a_q   <= a_d;
          q_q   <= q_d;
          q1_q  <= q1_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(w - 1)) begin
            p_q     <= {a_d[w-1:0], q_d};
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_p     = p_q;

`ifdef BOOTH_OPCOUNT_EN
  logic [CW-1:0] opc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opc_q <= '0;
    end else if (state_q == ST_IDLE && in_valid) begin
      opc_q <= '0;
    end else if (state_q == ST_CALC && op_c) begin
      opc_q <= opc_q + CW'(1);
    end
  end

  assign op_count = opc_q;
`endif

endmodule

// File: doc/booth_mul_block.md
Name: booth_mul_block

Overview:
Sequential signed radix-2 Booth multiplier built around the ripple-carry adder. It accepts two signed w-bit operands over a valid/ready handshake and performs one add, subtract or no-op per clock, followed by an arithmetic shift. It returns the signed 2w-bit product over a second valid/ready handshake. It sits downstream of the adder: it drives the adder's a, b and carry_in inputs every cycle and consumes the adder's out.

Parameters:
w, 64, operand width in bits; product is 2w bits; w >= 2.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset; rst=0 forces reset state immediately, release is synchronous to clk.
in_valid  in  1  operands present on in_a/in_b.
in_ready  out  1  block can accept operands.
in_a  in  w  multiplicand M, two's complement.
in_b  in  w  multiplier Q, two's complement.
out_valid  out  1  product valid.
out_ready  in  1  consumer takes product.
out_p  out  2w  signed product in_a*in_b.

Behaviour:
- States: IDLE, CALC, DONE. Reset: state=IDLE, in_ready=1, out_valid=0, out_p=0, all internal registers 0.
- in_ready = (state==IDLE); out_valid = (state==DONE); both are combinational from state.
- Accept: at an edge where state=IDLE and in_valid=1:
  - M <= sign-extend(in_a) to w+1 bits; Q <= in_b; A (w+1 bits) <= 0; Q_1 <= 0; iteration count <= 0; state -> CALC.
  - in_valid=0 in IDLE: no change.
- CALC, every edge:
  - {Q[0],Q_1}=01: A_new = A + M (adder b=M, carry_in=0).
  - {Q[0],Q_1}=10: A_new = A - M (adder b=~M, carry_in=1).
  - 00 or 11: A_new = A.
  - Then arithmetic shift right of {A_new,Q,Q_1} by 1 (A MSB replicated).
  - Count increments. At the edge completing iteration w: out_p <= {A[w-1:0],Q}, state -> DONE.
  - Latency: out_valid rises exactly w cycles after the accept edge (w=64: 64 cycles).
- Adder width is w+1 so M = -2^(w-1) never overflows; the result is exact for all operand pairs, including min*min.
- DONE: out_p is held stable while out_valid=1. At an edge with out_ready=1: state -> IDLE. out_ready=0 holds DONE indefinitely.
- No new operands are accepted until the edge after the product is taken. Throughput is one product per w+2 cycles minimum.
- in_a/in_b changes during CALC/DONE are ignored. out_ready during IDLE/CALC is ignored.
- Reset mid-CALC or mid-DONE: the operation is aborted, all outputs return to reset values, and no partial product is emitted.

Optional Feature:
BOOTH_OPCOUNT_EN
- Defined: adds output port op_count (width clog2(w+1)). Cleared on accept; increments in CALC on each iteration whose Booth pair is 01 or 10. Valid and held with out_p in DONE; 0 after reset.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package: state encoding (IDLE/CALC/DONE, 2 bits), Booth pair constants (BOOTH_NOP, BOOTH_ADD, BOOTH_SUB), and a clog2-based count-width function.
- One sub-module: sum_block instantiated with width w+1 for both add and subtract. Subtract uses inverted b with carry_in=1.
- Control FSM and shift register stay in booth_mul_block.

Test Plan:
- Reset: rst=0 with random inputs -> in_ready=1, out_valid=0, out_p=0. Release, then in_a=3, in_b=1 -> out_valid exactly 64 cycles after accept, out_p=3.
- Signs, w=64: (-5)*7 -> out_p = 2w-bit two's complement of -35 (0xFFFF...FFDD); then (-5)*(-7) -> 35; 0*(-1) -> 0.
- Extremes, w=8: (-128)*(-128) -> 0x4000; (-128)*127 -> 0xC080; 127*127 -> 0x3F01. Sweep all 65536 pairs against a signed reference model.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_p stable, in_ready=0, in_valid pulses ignored. Raise out_ready -> IDLE next edge; next operands accepted one cycle later.
- Reset mid-op: assert rst=0 at iteration 30 of 64 -> outputs at reset values immediately. Release and issue 2*2 -> 4 with normal latency.
- With BOOTH_OPCOUNT_EN, w=8: in_b=0x55 -> op_count=8; in_b=0xFF -> op_count=1; in_b=0 -> op_count=0.
